// File: rtl/mips_mem_bridge.sv
// Unified RAM / MMIO slave for the multicycle CPU memory port, with 1-cycle registered reads.
// Optional MIPS_MEM_BRIDGE_ALIGN_CHECK_EN: misaligned accesses raise bus_err and are suppressed.
module mips_mem_bridge #(
    parameter int         N         = 32,
    parameter int         RAM_AW    = 10,
    parameter logic [11:0] RAM_BASE = 12'h004,
    parameter logic [11:0] MMIO_BASE = 12'hFFF,
    parameter int         FIFO_AW   = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] mem_addr,
    input  logic [N-1:0] mem_wr_data,
    input  logic         mem_wr_ena,
    output logic [N-1:0] mem_rd_data,
    output logic [15:0]  leds,
    input  logic [15:0]  switches,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         bus_err
);
    localparam int FIFO_DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   CNT_ONE  = 1;
    localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW+1)'(FIFO_DEPTH);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = 1;

    logic [N-1:0]       ram [0:(1<<RAM_AW)-1];
    logic [N-1:0]       ram_rd_reg;
    logic               rd_from_ram_reg;
    logic [N-1:0]       mmio_rd_reg;
    logic [15:0]        leds_reg;
    logic [31:0]        cycle_reg;
    logic [15:0]        sw_meta_reg, sw_sync_reg;
    logic [7:0]         fifo_mem [0:FIFO_DEPTH-1];
    logic [FIFO_AW-1:0] head_reg, tail_reg;
    logic [FIFO_AW:0]   count_reg;
    logic               bus_err_reg;

    logic [RAM_AW-1:0]  word_idx;
    logic [5:0]         offset;
    logic               ram_hit, mmio_hit, misaligned;
    logic               mmio_bad, access_err;
    logic [N-1:0]       mmio_rd_next;
    logic [31:0]        cycle_next;
    logic               full, empty, pop, push_req, push_ok, overflow;
    logic               mmio_wr, cycle_clr, led_wr;
    logic               unused_addr_bits;

    assign word_idx   = mem_addr[RAM_AW+1:2];
    assign offset     = mem_addr[7:2];
    assign ram_hit    = (mem_addr[31:20] == RAM_BASE) &&
                        ({14'b0, mem_addr[19:2]} < (32'd1 << RAM_AW));
    assign mmio_hit   = (mem_addr[31:20] == MMIO_BASE);
`ifdef MIPS_MEM_BRIDGE_ALIGN_CHECK_EN
    assign misaligned = (mem_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif
    // Page bits above the offset are don't-care inside the MMIO page.
    assign unused_addr_bits = ^{mem_addr[19:8], mem_addr[1:0]};

    assign full       = (count_reg == CNT_FULL);
    assign empty      = (count_reg == '0);
    assign cycle_next = cycle_reg + 32'd1;

    always_comb begin
        mmio_rd_next = '0;
        mmio_bad     = 1'b0;
        case (offset)
            6'd0: mmio_rd_next = {{(N-16){1'b0}}, leds_reg};
            6'd1: mmio_rd_next = {{(N-16){1'b0}}, sw_sync_reg};
            6'd2: mmio_rd_next = cycle_next;  // value the counter holds once this read lands
            6'd3: mmio_rd_next = '0;
            6'd4: mmio_rd_next = {{(N-FIFO_AW-3){1'b0}}, count_reg, full, empty};
            default: mmio_bad = 1'b1;
        endcase
    end

    assign access_err = misaligned || (!ram_hit && !mmio_hit) || (mmio_hit && mmio_bad);
    assign mmio_wr    = mem_wr_ena && mmio_hit && !misaligned;
    assign led_wr     = mmio_wr && (offset == 6'd0);
    assign cycle_clr  = mmio_wr && (offset == 6'd2);
    assign push_req   = mmio_wr && (offset == 6'd3);
    assign pop        = !empty && tx_ready;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign push_ok    = push_req && (!full || pop);
    assign overflow   = push_req && !push_ok;

    always_ff @(posedge clk) begin
        if (mem_wr_ena && ram_hit && !misaligned)
            ram[word_idx] <= mem_wr_data;
        else if (!mem_wr_ena)
            ram_rd_reg <= ram[word_idx];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_from_ram_reg <= 1'b0;
            mmio_rd_reg     <= '0;
            leds_reg        <= '0;
            cycle_reg       <= '0;
            sw_meta_reg     <= '0;
            sw_sync_reg     <= '0;
            head_reg        <= '0;
            tail_reg        <= '0;
            count_reg       <= '0;
            bus_err_reg     <= 1'b0;
        end else begin
            if (!mem_wr_ena) begin
                rd_from_ram_reg <= ram_hit && !misaligned;
                mmio_rd_reg     <= (mmio_hit && !access_err) ? mmio_rd_next : '0;
            end
            if (led_wr)
                leds_reg <= mem_wr_data[15:0];
            cycle_reg   <= cycle_clr ? 32'd0 : cycle_next;
            sw_meta_reg <= switches;
            sw_sync_reg <= sw_meta_reg;
            if (access_err || overflow)
                bus_err_reg <= 1'b1;
            if (push_ok)
                tail_reg <= tail_reg + PTR_ONE;
            if (pop)
                head_reg <= head_reg + PTR_ONE;
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    fifo_mem[gi] <= '0;
                else if (push_ok && (tail_reg == FIFO_AW'(gi)))
                    fifo_mem[gi] <= mem_wr_data[7:0];
            end
        end
    endgenerate

    assign mem_rd_data = rd_from_ram_reg ? ram_rd_reg : mmio_rd_reg;
    assign leds        = leds_reg;
    assign tx_valid    = !empty;
    assign tx_data     = empty ? 8'h00 : fifo_mem[head_reg];
    assign bus_err     = bus_err_reg;
endmodule

// File: tb/tb_mips_mem_bridge.sv
// Randomised + directed bench for mips_mem_bridge against a transaction-level model.
module tb_mips_mem_bridge;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_addr = 32'h0040_0000;
    logic [31:0] mem_wr_data = '0;
    logic        mem_wr_ena = 1'b0;
    logic [31:0] mem_rd_data;
    logic [15:0] leds;
    logic [15:0] switches = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        bus_err;

    int total = 0;
    int bad   = 0;
    bit cmp_on = 0;

    mips_mem_bridge dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_ena(mem_wr_ena), .mem_rd_data(mem_rd_data), .leds(leds),
        .switches(switches), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Reference model state: what software would observe, by address map rules.
    logic [31:0] m_ram [0:1023];
    bit          m_known [0:1023];
    logic [15:0] m_leds;
    logic [31:0] m_cyc;
    logic [7:0]  m_q [$];
    bit          m_err;
    logic [15:0] m_sw_hist [0:1];
    logic [31:0] exp_rd;
    bit          exp_known;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_leds = '0; m_cyc = '0; m_q.delete(); m_err = 0;
        m_sw_hist[0] = '0; m_sw_hist[1] = '0;
        exp_rd = '0; exp_known = 1;
    endtask

    // Effect of one clock edge given the inputs presented during the cycle before it.
    task automatic model_step();
        logic [31:0] a;
        logic [9:0]  idx;
        bit ram, mmio, mis, popped, push;
        int n;
        a = mem_addr; idx = a[11:2];
        ram  = (a[31:20] == 12'h004) && (a[19:2] < 18'd1024);
        mmio = (a[31:20] == 12'hFFF);
`ifdef MIPS_MEM_BRIDGE_ALIGN_CHECK_EN
        mis = (a[1:0] != 2'b00);
`else
        mis = 0;
`endif
        n = m_q.size();
        popped = (n > 0) && tx_ready;
        push = 0;
        if (mem_wr_ena) begin
            if (mis || (!ram && !mmio)) m_err = 1;
            else if (ram) begin m_ram[idx] = mem_wr_data; m_known[idx] = 1; end
            else begin
                case (a[7:2])
                    6'd0: m_leds = mem_wr_data[15:0];
                    6'd1, 6'd4: ;
                    6'd2: m_cyc = 32'hFFFF_FFFF;  // becomes 0 after the +1 below
                    6'd3: push = 1;
                    default: m_err = 1;
                endcase
            end
        end else begin
            exp_rd = '0; exp_known = 1;
            if (mis || (!ram && !mmio)) m_err = 1;
            else if (ram) begin exp_rd = m_ram[idx]; exp_known = m_known[idx]; end
            else begin
                case (a[7:2])
                    6'd0: exp_rd = {16'h0, m_leds};
                    6'd1: exp_rd = {16'h0, m_sw_hist[1]};
                    6'd2: exp_rd = m_cyc + 32'd1;
                    6'd3: exp_rd = '0;
                    6'd4: exp_rd = (n << 2) | ((n == 4) ? 2 : 0) | ((n == 0) ? 1 : 0);
                    default: m_err = 1;
                endcase
            end
        end
        if (popped) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < 4) m_q.push_back(mem_wr_data[7:0]);
            else m_err = 1;
        end
        m_cyc = m_cyc + 32'd1;
        m_sw_hist[1] = m_sw_hist[0];
        m_sw_hist[0] = switches;
    endtask

    task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic we);
        mem_addr = a; mem_wr_data = d; mem_wr_ena = we;
        @(posedge clk);
        model_step();
        @(negedge clk);
        mem_wr_ena = 1'b0; mem_addr = 32'h0040_0000;
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            if (exp_known) chk("rd_data", mem_rd_data, exp_rd);
            chk("leds", {16'h0, leds}, {16'h0, m_leds});
            chk("bus_err", {31'h0, bus_err}, {31'h0, m_err});
            chk("tx_valid", {31'h0, tx_valid}, (m_q.size() != 0) ? 32'd1 : 32'd0);
            if (m_q.size() != 0) chk("tx_data", {24'h0, tx_data}, {24'h0, m_q[0]});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a, d;
        for (int i = 0; i < 1024; i++) m_known[i] = 0;
        #1 rst = 1'b0;
        model_reset();
        cmp_on = 1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        chk("reset_rd", mem_rd_data, 32'h0);
        chk("reset_leds", {16'h0, leds}, 32'h0);
        chk("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("reset_tx_data", {24'h0, tx_data}, 32'h0);
        chk("reset_err", {31'h0, bus_err}, 32'h0);

        // Preload word 0 and read it back after one cycle.
        cyc(32'h0040_0000, 32'hCAFE_F00D, 1'b1);
        cyc(32'h0040_0014, 32'hA5A5_0014, 1'b1);
        cyc(32'h0040_0000, 32'h0, 1'b0);
        chk("ram_first_read", mem_rd_data, 32'hCAFE_F00D);
        cyc(32'h0040_0010, 32'h1234_5678, 1'b1);
        cyc(32'h0040_0010, 32'h0, 1'b0);
        chk("raw_same_addr", mem_rd_data, 32'h1234_5678);
        cyc(32'h0040_0014, 32'h0, 1'b0);
        chk("neighbour_word", mem_rd_data, 32'hA5A5_0014);
        chk("err_clean", {31'h0, bus_err}, 32'h0);

        // Misaligned write handling depends on the alignment-check build option.
        cyc(32'h0040_0002, 32'hFFFF_FFFF, 1'b1);
        cyc(32'h0040_0000, 32'h0, 1'b0);
`ifdef MIPS_MEM_BRIDGE_ALIGN_CHECK_EN
        chk("misaligned_word", mem_rd_data, 32'hCAFE_F00D);
        chk("misaligned_err", {31'h0, bus_err}, 32'h1);
`else
        chk("misaligned_word", mem_rd_data, 32'hFFFF_FFFF);
        chk("misaligned_err", {31'h0, bus_err}, 32'h0);
`endif

        // Cycle counter reload and back-to-back reads.
        cyc(32'hFFF0_0008, 32'hDEAD_BEEF, 1'b1);
        cyc(32'hFFF0_0008, 32'h0, 1'b0);
        chk("cycle_first", mem_rd_data, 32'd1);
        cyc(32'hFFF0_0008, 32'h0, 1'b0);
        chk("cycle_second", mem_rd_data, 32'd2);

        // Push during pop with two queued keeps count at two.
        tx_ready = 1'b0;
        cyc(32'hFFF0_000C, 32'h61, 1'b1);
        cyc(32'hFFF0_000C, 32'h62, 1'b1);
        tx_ready = 1'b1;
        cyc(32'hFFF0_000C, 32'h55, 1'b1);
        tx_ready = 1'b0;
        cyc(32'hFFF0_0010, 32'h0, 1'b0);
        chk("status_count2", mem_rd_data, 32'h08);
        chk("head_after_pushpop", {24'h0, tx_data}, 32'h62);
        tx_ready = 1'b1;
        cyc(32'h0040_0000, 32'h0, 1'b0);
        chk("pushed_after_old", {24'h0, tx_data}, 32'h55);
        cyc(32'h0040_0000, 32'h0, 1'b0);
        chk("drained", {31'h0, tx_valid}, 32'h0);
        tx_ready = 1'b0;
        chk("err_before_overflow", {31'h0, bus_err}, 32'h0);

        // Overflow: fifth byte dropped, error raised, head still first byte.
        for (int i = 0; i < 5; i++) cyc(32'hFFF0_000C, 32'h41 + i, 1'b1);
        cyc(32'hFFF0_0010, 32'h0, 1'b0);
        chk("status_full", mem_rd_data, 32'h12);
        chk("overflow_err", {31'h0, bus_err}, 32'h1);
        chk("full_head", {24'h0, tx_data}, 32'h41);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", {24'h0, tx_data}, 32'h41 + i);
            cyc(32'h0040_0000, 32'h0, 1'b0);
        end
        chk("drain_empty", {31'h0, tx_valid}, 32'h0);
        tx_ready = 1'b0;

        // Reset asserted while an LED write is on the bus.
        cyc(32'hFFF0_0000, 32'h0000_ABCD, 1'b1);
        chk("led_write", {16'h0, leds}, 32'h0000_ABCD);
        mem_addr = 32'hFFF0_0000; mem_wr_data = 32'h1111; mem_wr_ena = 1'b1;
        #2 rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        mem_wr_ena = 1'b0; mem_addr = 32'h0040_0000;
        rst = 1'b1;
        chk("midreset_leds", {16'h0, leds}, 32'h0);
        chk("midreset_err", {31'h0, bus_err}, 32'h0);

        cyc(32'h1000_0000, 32'h0, 1'b0);
        chk("unmapped_rd", mem_rd_data, 32'h0);
        chk("unmapped_err", {31'h0, bus_err}, 32'h1);

        // Random traffic over RAM, MMIO and unmapped space.
        for (int i = 0; i < 3000; i++) begin
            if ((i % 8) == 0) switches = 16'($urandom);
            tx_ready = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 9))
                0, 1, 2, 3: a = 32'h0040_0000 | ($urandom_range(0, 15) << 2);
                4:          a = 32'h0040_0FFC;
                5, 6:       a = 32'hFFF0_0000 | ($urandom_range(0, 5) << 2);
                7:          a = 32'h0040_1000 | ($urandom_range(0, 15) << 2);
                8:          a = $urandom;
                default:    a = 32'h0040_0000 | $urandom_range(0, 63);
            endcase
            d = $urandom;
            cyc(a, d, ($urandom_range(0, 9) < 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mips_mem_bridge.md
Name: mips_mem_bridge

Overview:
- Unified memory/MMIO slave sitting directly downstream of the von Neumann multicycle CPU's single memory port (mem_addr, mem_wr_data, mem_wr_ena, mem_rd_data).
- Decodes each access to one of three targets: a word-addressed synchronous RAM holding instructions and data, an MMIO peripheral page (LEDs, switches, cycle counter, TX FIFO), or unmapped space.
- Read data is registered with exactly one cycle of latency, which matches the CPU's FETCH1→FETCH2 and MEMORY1→MEMORY2 timing.

Parameters:
- N, 32, data/address width.
- RAM_AW, 10, RAM word-address bits (2^RAM_AW words).
- RAM_BASE, 12'h004, mem_addr[31:20] value selecting RAM; must equal the CPU instruction start page.
- MMIO_BASE, 12'hFFF, mem_addr[31:20] value selecting the MMIO page.
- FIFO_AW, 2, TX FIFO depth is 2^FIFO_AW entries (4).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- mem_addr  in  N  byte address from CPU.
- mem_wr_data  in  N  write data.
- mem_wr_ena  in  1  write strobe, one cycle per write.
- mem_rd_data  out  N  registered read data.
- leds  out  16  LED register.
- switches  in  16  asynchronous board switches.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  consumer accepts head when tx_valid & tx_ready.
- bus_err  out  1  sticky error flag.

Behaviour:
- Reset (rst low, asynchronous assert, synchronous release): mem_rd_data=0, leds=0, tx_valid=0, tx_data=0, bus_err=0, cycle counter=0, FIFO pointers/count=0, switch synchronisers=0. RAM contents are not reset.
- Decode: RAM hit when mem_addr[31:20]==RAM_BASE and mem_addr[19:2] < 2^RAM_AW. MMIO hit when mem_addr[31:20]==MMIO_BASE. Anything else is unmapped. Word index is mem_addr[RAM_AW+1:2].
- Read: every cycle with mem_wr_ena=0, mem_rd_data <= selected word at the next edge. Latency is 1. An address presented in cycle t is visible in cycle t+1.
- Unmapped read returns 0 and sets bus_err.
- Write: committed at the edge where mem_wr_ena=1. mem_rd_data holds its previous value during a write cycle.
- Back-to-back read after write to the same address returns the new data.
- Unmapped write is dropped and sets bus_err.
- MMIO offsets (mem_addr[7:0]); others are unmapped:
  - 0x00 LED: R/W, low 16 bits used, upper bits read 0.
  - 0x04 SWITCH: RO; value is switches after a 2-flop synchroniser. Write is ignored, no error.
  - 0x08 CYCLE: free-running 32-bit counter, +1 every cycle, wraps FFFF_FFFF→0. A write loads 0; the read in the following cycle returns 1.
  - 0x0C TX_DATA: write pushes wr_data[7:0]. Read returns 0.
  - 0x10 TX_STATUS: RO {27'b0, count[2:0], full, empty}; count ranges 0..4.
- TX FIFO: circular buffer with a separate count register.
  - tx_data = head entry; tx_valid = !empty. Both are combinational from FIFO state.
  - Pop on tx_valid & tx_ready. Pop when empty is impossible because tx_valid=0.
  - Push when full: byte dropped, bus_err set, count unchanged.
  - Push and pop in the same cycle with count in 1..4: both happen and count is unchanged. When full, a simultaneous push and pop succeeds because the pop frees the slot first.
  - Push into empty FIFO: tx_valid=1 in the next cycle.
- bus_err is sticky until reset.
- Reset mid-operation: an in-flight write at the reset edge is not committed to MMIO state. The RAM write may or may not complete; software must not rely on it.

Optional Feature:
- Macro MIPS_MEM_BRIDGE_ALIGN_CHECK_EN.
- Defined: any access with mem_addr[1:0]!=0 sets bus_err, suppresses the write, and returns 0 on read.
- Undefined: mem_addr[1:0] is ignored, the access proceeds at the word, and no error is raised.

Test Plan:
- Reset, then read 0x0040_0000 in cycle t → mem_rd_data=preloaded word at cycle t+1; leds=0, bus_err=0 throughout.
- Write 0x1234_5678 to 0x0040_0010, next cycle read 0x0040_0010 → 0x1234_5678 one cycle later; a read of 0x0040_0014 is unaffected.
- Hold tx_ready=0, write 0x41,0x42,0x43,0x44,0x45 to 0xFFF0_000C → TX_STATUS=0x12 (count 4, full); bus_err=1; tx_data=0x41. Then raise tx_ready for 4 cycles → bytes 41,42,43,44 delivered in order, then tx_valid=0.
- With count=2 and tx_ready=1, push 0x55 in the same cycle as a pop → count stays 2, 0x55 emerges after the existing bytes.
- Write any value to 0xFFF0_0008, then read it back-to-back → 1, then 2. Read 0x1000_0000 → 0 and bus_err=1.
- With MIPS_MEM_BRIDGE_ALIGN_CHECK_EN defined, write 0xFFFF_FFFF to 0x0040_0002 → word at 0x0040_0000 unchanged, bus_err=1. Without the macro, the word at 0x0040_0000 becomes 0xFFFF_FFFF and bus_err=0.
